div_sign_ctrl: RTL and testbench

//  Sequencing and sign-handling stage wrapped around the combinational unsigned divider.

---
 rtl/div_pkg.sv | 16 +
 rtl/serial_mul_lo.sv | 48 ++++
 rtl/div_sign_ctrl.sv | 166 ++++++++++++++++
 tb/tb_div_sign_ctrl.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the signed/unsigned divide sequencer.
package div_pkg;

    localparam int DIV_WIDTH = 32;

    // Quotient reported for a zero divisor.
    localparam logic [DIV_WIDTH-1:0] DBZ_QUOTIENT = '1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_MULT   = 2'd2,
        ST_FIX    = 2'd3
    } div_state_e;

endpackage

// File: rtl/serial_mul_lo.sv
// Serial shift-add multiplier keeping only the low WIDTH bits of the product.
module serial_mul_lo #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] mcand,
    input  logic [WIDTH-1:0] mplier,
    output logic [WIDTH-1:0] acc
);

    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        if (load) begin
            mcand_d  = mcand;
            mplier_d = mplier;
            acc_d    = '0;
        end else if (step) begin
            // Multiplier shifts right so bit 0 is always the current partial product select.
            if (mplier_q[0]) acc_d = acc_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/div_sign_ctrl.sv
// Sign handling and sequencing around an external combinational unsigned divider;
// remainder is rebuilt as |a| - q*|b| using a serial multiplier.
module div_sign_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH         = DIV_WIDTH,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] div_a,
    output logic [WIDTH-1:0] div_b,
    input  logic [WIDTH-1:0] div_q,
    output logic             busy,
    output logic             done,
    output logic             dbz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_MAX = (SETTLE_CYCLES > WIDTH) ? SETTLE_CYCLES : WIDTH;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] div_a_q, div_a_d;
    logic [WIDTH-1:0] div_b_q, div_b_d;
    logic [WIDTH-1:0] raw_a_q, raw_a_d;
    logic [WIDTH-1:0] q_reg_q, q_reg_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             dbz_pend_q, dbz_pend_d;
    logic             dbz_q, dbz_d;
    logic             done_q, done_d;

    logic             mul_load, mul_step;
    logic [WIDTH-1:0] mul_acc;
    logic [WIDTH-1:0] mag_a, mag_b, rem;
    logic             a_neg, b_neg;

    assign a_neg = signed_op & op_a[WIDTH-1];
    assign b_neg = signed_op & op_b[WIDTH-1];
    assign mag_a = a_neg ? -op_a : op_a;
    assign mag_b = b_neg ? -op_b : op_b;
    assign rem   = div_a_q - mul_acc;

    serial_mul_lo #(.WIDTH(WIDTH)) u_mul (
        .clk    (clk),
        .clr_n  (clr_n),
        .load   (mul_load),
        .step   (mul_step),
        .mcand  (div_b_q),
        .mplier (div_q),
        .acc    (mul_acc)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_a_d    = div_a_q;
        div_b_d    = div_b_q;
        raw_a_d    = raw_a_q;
        q_reg_d    = q_reg_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        q_neg_d    = q_neg_q;
        r_neg_d    = r_neg_q;
        dbz_pend_d = dbz_pend_q;
        dbz_d      = dbz_q;
        done_d     = 1'b0;
        mul_load   = 1'b0;
        mul_step   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    div_a_d    = mag_a;
                    div_b_d    = mag_b;
                    raw_a_d    = op_a;
                    q_neg_d    = a_neg ^ b_neg;
                    r_neg_d    = a_neg;
                    cnt_d      = CNT_W'(SETTLE_CYCLES - 1);
                    dbz_d      = 1'b0;
                    dbz_pend_d = (op_b == '0);
                    state_d    = (op_b == '0) ? ST_FIX : ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    q_reg_d  = div_q;
                    mul_load = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_MULT;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_MULT: begin
                mul_step = 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) state_d = ST_FIX;
                else                            cnt_d   = cnt_q + 1'b1;
            end
            ST_FIX: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
                if (dbz_pend_q) begin
                    lo_d  = WIDTH'(DBZ_QUOTIENT);
                    hi_d  = raw_a_q;
                    dbz_d = 1'b1;
                end else begin
                    lo_d = q_neg_q ? -q_reg_q : q_reg_q;
                    hi_d = r_neg_q ? -rem : rem;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            div_a_q    <= '0;
            div_b_q    <= '0;
            raw_a_q    <= '0;
            q_reg_q    <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            dbz_pend_q <= 1'b0;
            dbz_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_a_q    <= div_a_d;
            div_b_q    <= div_b_d;
            raw_a_q    <= raw_a_d;
            q_reg_q    <= q_reg_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            q_neg_q    <= q_neg_d;
            r_neg_q    <= r_neg_d;
            dbz_pend_q <= dbz_pend_d;
            dbz_q      <= dbz_d;
            done_q     <= done_d;
        end
    end

    // Busy drops in the same cycle done rises, so a start alongside done is accepted.
    assign busy  = (state_q != ST_IDLE);
    assign done  = done_q;
    assign dbz   = dbz_q;
    assign hi    = hi_q;
    assign lo    = lo_q;
    assign div_a = div_a_q;
    assign div_b = div_b_q;

endmodule

// File: tb/tb_div_sign_ctrl.sv
// Directed bench for div_sign_ctrl with a behavioural unsigned divider attached.
module tb_div_sign_ctrl;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         clr_n;
    logic         start;
    logic         signed_op;
    logic [W-1:0] op_a, op_b;
    logic [W-1:0] div_a, div_b, div_q;
    logic         busy, done, dbz;
    logic [W-1:0] hi, lo;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign div_q = (div_b != '0) ? (div_a / div_b) : '0;

    div_sign_ctrl #(.WIDTH(W), .SETTLE_CYCLES(4)) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .start     (start),
        .signed_op (signed_op),
        .op_a      (op_a),
        .op_b      (op_b),
        .div_a     (div_a),
        .div_b     (div_b),
        .div_q     (div_q),
        .busy      (busy),
        .done      (done),
        .dbz       (dbz),
        .hi        (hi),
        .lo        (lo)
    );

    task automatic chk(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Waits (bounded) for done after the accepting edge; returns edge count, 100 on timeout.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input int exp_lat, input logic [W-1:0] exp_lo,
                         input logic [W-1:0] exp_hi, input logic exp_dbz);
        int lat;
        @(negedge clk);
        start = 1'b1; op_a = a; op_b = b; signed_op = s;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, ".busy0"}, W'(busy), 32'd1);
        chk({tag, ".dbzclr"}, W'(dbz), 32'd0);
        wait_done(lat);
        chk({tag, ".lat"}, W'(lat), W'(exp_lat));
        chk({tag, ".lo"}, lo, exp_lo);
        chk({tag, ".hi"}, hi, exp_hi);
        chk({tag, ".dbz"}, W'(dbz), W'(exp_dbz));
        chk({tag, ".busyd"}, W'(busy), 32'd0);
    endtask

    initial begin
        int lat;
        clr_n = 1'b0; start = 1'b0; signed_op = 1'b0; op_a = '0; op_b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.busy", W'(busy), 32'd0);
        chk("rst.done", W'(done), 32'd0);
        chk("rst.lo", lo, 32'd0);
        chk("rst.hi", hi, 32'd0);
        chk("rst.diva", div_a, 32'd0);
        @(negedge clk) clr_n = 1'b1;

        do_op("u100_7",  32'd100,      32'd7,          1'b0, 37, 32'd14,       32'd2,        1'b0);
        do_op("sm100_7", 32'hFFFF_FF9C, 32'd7,         1'b1, 37, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
        do_op("s100_m7", 32'd100,      32'hFFFF_FFF9,  1'b1, 37, 32'hFFFF_FFF2, 32'd2,        1'b0);
        do_op("dbz",     32'h1234,     32'd0,          1'b0, 1,  32'hFFFF_FFFF, 32'h1234,     1'b1);
        do_op("dbzs",    32'hFFFF_FF9C, 32'd0,         1'b1, 1,  32'hFFFF_FFFF, 32'hFFFF_FF9C, 1'b1);
        do_op("clrdbz",  32'd100,      32'd7,          1'b0, 37, 32'd14,       32'd2,        1'b0);
        do_op("ovf_s",   32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 37, 32'h8000_0000, 32'd0,        1'b0);
        do_op("ovf_u",   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 37, 32'd0,        32'h8000_0000, 1'b0);
        do_op("u_big",   32'hFFFF_FFFF, 32'd10,        1'b0, 37, 32'h1999_9999, 32'd5,        1'b0);

        // Starts while busy must be ignored.
        @(negedge clk);
        start = 1'b1; op_a = 32'd100; op_b = 32'd7; signed_op = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; op_a = 32'd50; op_b = 32'd5;
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            start = (lat == 4 || lat == 19);
            if (lat == 25) chk("hs.diva", div_a, 32'd100);
        end
        chk("hs.lat", W'(lat), 32'd37);
        chk("hs.lo", lo, 32'd14);
        chk("hs.hi", hi, 32'd2);
        // Start in the done cycle is accepted.
        start = 1'b1; op_a = 32'd1000; op_b = 32'd10;
        @(posedge clk); #1;
        start = 1'b0;
        chk("bb.busy", W'(busy), 32'd1);
        chk("bb.done", W'(done), 32'd0);
        wait_done(lat);
        chk("bb.lat", W'(lat), 32'd37);
        chk("bb.lo", lo, 32'd100);
        chk("bb.hi", hi, 32'd0);

        // Reset mid-op.
        @(negedge clk);
        start = 1'b1; op_a = 32'd77; op_b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1 clr_n = 1'b0;
        @(posedge clk); #1;
        chk("mr.busy", W'(busy), 32'd0);
        chk("mr.done", W'(done), 32'd0);
        chk("mr.lo", lo, 32'd0);
        chk("mr.hi", hi, 32'd0);
        chk("mr.diva", div_a, 32'd0);
        chk("mr.divb", div_b, 32'd0);
        @(negedge clk) clr_n = 1'b1;
        do_op("post_rst", 32'd200, 32'd9, 1'b0, 37, 32'd22, 32'd2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
